// File: rtl/gcd_datapath_unit.sv
// ---------------------------------------------------------------------------
// gcd_datapath_unit
//
// Purpose:
//   Datapath half of a subtractive GCD engine. The controller steers it with
//   load and select strobes and receives the magnitude compare flags back.
//   The unit holds operands A and B, one shared subtractor, and the input and
//   subtract muxes. It also provides three registered side functions:
//     - result capture on the rising edge of done
//     - a saturating iteration counter
//     - sticky misuse flags (zero subtrahend, illegal strobe combination)
//
// Optional feature (macro GCD_ITER_LIMIT_EN):
//   When defined, the unit adds a 'timeout' output. timeout is set when
//   iter_count reaches ITER_LIMIT. While timeout is set, all subtract loads
//   are blocked. A legal operand-A load clears timeout.
//   When the macro is undefined there is no timeout port and ITER_LIMIT is
//   unused.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   data_in      in   [WIDTH] operand bus from host
//   ldA, ldB     in   load A / load B from the internal bus
//   sel1         in   subtractor minuend select   (1 = B, 0 = A)
//   sel2         in   subtractor subtrahend select (1 = B, 0 = A)
//   sel_in       in   bus select (1 = data_in, 0 = subtractor output)
//   done         in   controller done level
//   lt, gt, eq   out  A < B, A > B, A == B (from registered A and B)
//   result       out  [WIDTH] captured GCD
//   result_valid out  result holds a valid GCD
//   iter_count   out  [CNT_W] subtract loads since the last operand-A load
//   zero_err     out  sticky: subtract load with a zero subtrahend
//   proto_err    out  sticky until reset: illegal strobe combination
//   timeout      out  iteration limit reached (only with GCD_ITER_LIMIT_EN)
// ---------------------------------------------------------------------------
module gcd_datapath_unit #(
  parameter int WIDTH      = 16,
  parameter int CNT_W      = 8,
  parameter int ITER_LIMIT = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ldA,
  input  logic             ldB,
  input  logic             sel1,
  input  logic             sel2,
  input  logic             sel_in,
  input  logic             done,
  output logic             lt,
  output logic             gt,
  output logic             eq,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic [CNT_W-1:0] iter_count,
  output logic             zero_err,
  output logic             proto_err
`ifdef GCD_ITER_LIMIT_EN
  ,
  output logic             timeout
`endif
);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_result_valid;
  logic [CNT_W-1:0] r_iter_count;
  logic             r_zero_err;
  logic             r_proto_err;
  logic             r_done_d;

  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH-1:0] w_bus;
  logic             w_load;
  logic             w_illegal;
  logic             w_legal_load;
  logic             w_opa_load;
  logic             w_sub_load;
  logic             w_sub_allow;
  logic             w_sub_write;
  logic             w_write_en;
  logic             w_done_rise;
  logic [CNT_W-1:0] w_iter_inc;

  // Operand muxes, shared subtractor and bus select.
  assign w_x   = sel1 ? r_b : r_a;
  assign w_y   = sel2 ? r_b : r_a;
  assign w_sub = w_x - w_y;
  assign w_bus = sel_in ? data_in : w_sub;

  // A cycle is illegal in any of these cases:
  //   - both registers are loaded at once;
  //   - a subtract load selects the same operand twice (the result is
  //     always zero);
  //   - a subtract load would wrap below zero.
  // An illegal cycle writes nothing.
  assign w_load       = ldA | ldB;
  assign w_illegal    = (ldA & ldB)
                      | (w_load & ~sel_in & (sel1 == sel2))
                      | (w_load & ~sel_in & (w_x < w_y));
  assign w_legal_load = w_load & ~w_illegal;
  assign w_opa_load   = w_legal_load & sel_in & ldA;
  assign w_sub_load   = w_legal_load & ~sel_in;

  // The saturating increment is computed here, outside the counter's
  // always block, so the timeout logic can compare against the post-edge
  // counter value.
  assign w_iter_inc  = (r_iter_count == {CNT_W{1'b1}}) ? r_iter_count
                                                       : r_iter_count + CNT_W'(1);

  assign w_done_rise = done & ~r_done_d;

`ifdef GCD_ITER_LIMIT_EN
  logic r_timeout;

  // While the watchdog is tripped, subtract loads are blocked, so the
  // operands and the counter stay frozen.
  assign w_sub_allow = ~r_timeout;
  assign timeout     = r_timeout;

  // Watchdog flag: set when an accepted subtract brings the counter to the
  // limit; cleared only when a fresh operand A is loaded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_timeout <= 1'b0;
    end else if (w_opa_load) begin
      r_timeout <= 1'b0;
    end else if (w_sub_write && (w_iter_inc == CNT_W'(ITER_LIMIT))) begin
      r_timeout <= 1'b1;
    end
  end
`else
  assign w_sub_allow = 1'b1;
`endif

  assign w_sub_write = w_sub_load & w_sub_allow;
  assign w_write_en  = w_legal_load & (sel_in | w_sub_allow);

  // Operand registers: each is written from the shared bus on its own
  // strobe, but only when the cycle is legal and not blocked.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
    end else if (w_write_en) begin
      if (ldA) r_a <= w_bus;
      if (ldB) r_b <= w_bus;
    end
  end

  // Iteration counter: restarts when a fresh operand A is loaded, and
  // counts accepted subtract loads up to all ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_iter_count <= '0;
    end else if (w_opa_load) begin
      r_iter_count <= '0;
    end else if (w_sub_write) begin
      r_iter_count <= w_iter_inc;
    end
  end

  // Misuse flags.
  //   zero_err: set by a legal subtract load with a zero subtrahend (the
  //             write itself still happens); cleared by a new operand A.
  //   proto_err: sticky until reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_zero_err  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_opa_load) begin
        r_zero_err <= 1'b0;
      end else if (w_sub_load && (w_y == '0)) begin
        r_zero_err <= 1'b1;
      end
      if (w_illegal) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  // Result capture happens on the rising edge of done only, so holding done
  // high does not recapture. A new operand A takes priority over a
  // coincident done rise: the old result is then kept, but marked invalid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_done_d       <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_done_d <= done;
      if (w_opa_load) begin
        r_result_valid <= 1'b0;
      end else if (w_done_rise) begin
        r_result       <= r_a;
        r_result_valid <= 1'b1;
      end
    end
  end

  // Magnitude compare uses registered operands only, so exactly one flag
  // is high at any time.
  assign lt = (r_a < r_b);
  assign gt = (r_a > r_b);
  assign eq = (r_a == r_b);

  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign iter_count   = r_iter_count;
  assign zero_err     = r_zero_err;
  assign proto_err    = r_proto_err;

endmodule

// File: tb/tb_gcd_datapath_unit.sv
// ---------------------------------------------------------------------------
// tb_gcd_datapath_unit
//
// Purpose:
//   Self-checking bench for gcd_datapath_unit. Table records hold one cycle of
//   strobes plus the outputs expected after that edge. Expected outputs are
//   queued when a record is driven and popped when the DUT output is sampled
//   just after the clock edge. Hand-written sequences cover counter
//   saturation and, when GCD_ITER_LIMIT_EN is defined, the watchdog.
// ---------------------------------------------------------------------------
module tb_gcd_datapath_unit;

  localparam int W  = 16;
  localparam int CW = 8;

  localparam logic [2:0] LT = 3'b100;
  localparam logic [2:0] GT = 3'b010;
  localparam logic [2:0] EQ = 3'b001;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  data_in;
  logic          ldA, ldB, sel1, sel2, sel_in, done;
  logic          lt, gt, eq;
  logic [W-1:0]  result;
  logic          result_valid;
  logic [CW-1:0] iter_count;
  logic          zero_err, proto_err;

  // Outputs from the default-limit instance are compared against the table.
  gcd_datapath_unit #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in),
    .ldA(ldA), .ldB(ldB), .sel1(sel1), .sel2(sel2), .sel_in(sel_in),
    .done(done), .lt(lt), .gt(gt), .eq(eq),
    .result(result), .result_valid(result_valid), .iter_count(iter_count),
    .zero_err(zero_err), .proto_err(proto_err)
`ifdef GCD_ITER_LIMIT_EN
    , .timeout()
`endif
  );

`ifdef GCD_ITER_LIMIT_EN
  logic          limLt, limGt, limEq, limRv, limZero, limProto, limTimeout;
  logic [W-1:0]  limResult;
  logic [CW-1:0] limIter;

  // Second instance with a small limit for the watchdog sequence.
  gcd_datapath_unit #(.WIDTH(W), .CNT_W(CW), .ITER_LIMIT(3)) dutLim (
    .clk(clk), .rst_n(rst_n), .data_in(data_in),
    .ldA(ldA), .ldB(ldB), .sel1(sel1), .sel2(sel2), .sel_in(sel_in),
    .done(done), .lt(limLt), .gt(limGt), .eq(limEq),
    .result(limResult), .result_valid(limRv), .iter_count(limIter),
    .zero_err(limZero), .proto_err(limProto), .timeout(limTimeout)
  );
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    cmpFlags;
    logic [W-1:0]  result;
    logic          rv;
    logic [CW-1:0] iter;
    logic          zero;
    logic          proto;
  } exp_t;

  typedef struct {
    logic         rst_n, ldA, ldB, sel1, sel2, sel_in, done;
    logic [W-1:0] data;
    exp_t         e;
  } vec_t;

  vec_t vecs[$];
  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;

  // Builds one record: reset, strobes, data, then the expected outputs.
  function automatic vec_t mk(logic r, logic a, logic b, logic s1, logic s2,
                              logic si, logic d, int data, logic [2:0] cmpF,
                              int res, logic rv, int it, logic z, logic p);
    vec_t v;
    v.rst_n = r; v.ldA = a; v.ldB = b; v.sel1 = s1; v.sel2 = s2;
    v.sel_in = si; v.done = d; v.data = W'(data);
    v.e.cmpFlags = cmpF; v.e.result = W'(res); v.e.rv = rv;
    v.e.iter = CW'(it); v.e.zero = z; v.e.proto = p;
    return v;
  endfunction

  // Single comparison; prints one line on a difference.
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Drives one record at the falling edge and waits until just after the
  // next rising edge.
  task automatic driveVec(input vec_t v);
    @(negedge clk);
    rst_n = v.rst_n; ldA = v.ldA; ldB = v.ldB; sel1 = v.sel1; sel2 = v.sel2;
    sel_in = v.sel_in; done = v.done; data_in = v.data;
    @(posedge clk);
    #1;
  endtask

  // Pops the oldest expectation and compares it against the DUT outputs.
  task automatic checkOutput(input string tag);
    exp_t e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s scoreboard: got empty queue expected entry", tag);
    end else begin
      e = expQ.pop_front();
      cmp({tag, " lt"},    32'(lt), 32'(e.cmpFlags[2]));
      cmp({tag, " gt"},    32'(gt), 32'(e.cmpFlags[1]));
      cmp({tag, " eq"},    32'(eq), 32'(e.cmpFlags[0]));
      cmp({tag, " result"}, 32'(result), 32'(e.result));
      cmp({tag, " rv"},    32'(result_valid), 32'(e.rv));
      cmp({tag, " iter"},  32'(iter_count), 32'(e.iter));
      cmp({tag, " zero"},  32'(zero_err), 32'(e.zero));
      cmp({tag, " proto"}, 32'(proto_err), 32'(e.proto));
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    expQ.push_back(v.e);
    driveVec(v);
    checkOutput(tag);
  endtask

  initial begin
    rst_n = 1'b0; ldA = 1'b0; ldB = 1'b0; sel1 = 1'b0; sel2 = 1'b0;
    sel_in = 1'b0; done = 1'b0; data_in = '0;

    //            r a b s1 s2 si d  data flags res rv it z p
    // GCD(48,18): 48-18=30, 30-18=12, 18-12=6, 12-6=6
    vecs.push_back(mk(0,0,0,0,0,0,0,  0, EQ,  0,0,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,1,0, 48, GT,  0,0,0,0,0));
    vecs.push_back(mk(1,0,1,0,0,1,0, 18, GT,  0,0,0,0,0));
    vecs.push_back(mk(1,1,0,0,1,0,0,  0, GT,  0,0,1,0,0));
    vecs.push_back(mk(1,1,0,0,1,0,0,  0, LT,  0,0,2,0,0));
    vecs.push_back(mk(1,0,1,1,0,0,0,  0, GT,  0,0,3,0,0));
    vecs.push_back(mk(1,1,0,0,1,0,0,  0, EQ,  0,0,4,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,1,  0, EQ,  6,1,4,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,1,  0, EQ,  6,1,4,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,  0, EQ,  6,1,4,0,0));
    // Equal operands: capture with no subtraction
    vecs.push_back(mk(1,1,0,0,0,1,0,  7, GT,  6,0,0,0,0));
    vecs.push_back(mk(1,0,1,0,0,1,0,  7, EQ,  6,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,1,  0, EQ,  7,1,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,  0, EQ,  7,1,0,0,0));
    // Zero subtrahend: B = B - A with A = 0 keeps B = 5 and flags zero_err
    vecs.push_back(mk(1,1,0,0,0,1,0,  0, LT,  7,0,0,0,0));
    vecs.push_back(mk(1,0,1,0,0,1,0,  5, LT,  7,0,0,0,0));
    vecs.push_back(mk(1,0,1,1,0,0,0,  0, LT,  7,0,1,1,0));
    vecs.push_back(mk(1,0,0,0,0,0,1,  0, LT,  0,1,1,1,0));
    vecs.push_back(mk(1,1,0,0,0,1,1,  9, GT,  0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,  0, GT,  0,0,0,0,0));
    // Protocol errors: double load, then underflowing subtract 2 - 5
    vecs.push_back(mk(1,1,1,0,0,1,0,  3, GT,  0,0,0,0,1));
    vecs.push_back(mk(1,1,0,0,0,1,0,  2, LT,  0,0,0,0,1));
    vecs.push_back(mk(1,1,0,0,1,0,0,  0, LT,  0,0,0,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,1,  0, LT,  2,1,0,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,0,  0, LT,  2,1,0,0,1));
    // Reset mid-run (A = 30, B = 18) wins over a coincident load
    vecs.push_back(mk(1,1,0,0,0,1,0, 30, GT,  2,0,0,0,1));
    vecs.push_back(mk(1,0,1,0,0,1,0, 18, GT,  2,0,0,0,1));
    vecs.push_back(mk(0,1,0,0,0,1,0, 99, EQ,  0,0,0,0,0));
    // Same-operand subtract (sel1 == sel2) is illegal
    vecs.push_back(mk(1,1,0,0,0,1,0,  5, GT,  0,0,0,0,0));
    vecs.push_back(mk(1,0,1,0,0,1,0,  5, EQ,  0,0,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,0,0,  0, EQ,  0,0,0,0,1));
    // done held high: single capture, no recapture after the result is cleared
    vecs.push_back(mk(0,0,0,0,0,0,0,  0, EQ,  0,0,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,1,0, 12, GT,  0,0,0,0,0));
    vecs.push_back(mk(1,0,1,0,0,1,0, 12, EQ,  0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,1,  0, EQ, 12,1,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,1,1, 20, GT, 12,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,1,  0, GT, 12,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,1,  0, GT, 12,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,1,  0, GT, 12,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,  0, GT, 12,0,0,0,0));
    // Done rise together with an operand-A load: the load wins
    vecs.push_back(mk(1,1,0,0,0,1,1,  8, LT, 12,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,1,  0, LT, 12,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,  0, LT, 12,0,0,0,0));

    foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("vec%0d", i));

`ifndef GCD_ITER_LIMIT_EN
    // Counter saturation: A = 300, B = 1, then 260 subtracts of A = A - B.
    applyStimulus(mk(0,0,0,0,0,0,0,   0, EQ, 0,0,0,0,0), "sat reset");
    applyStimulus(mk(1,1,0,0,0,1,0, 300, GT, 0,0,0,0,0), "sat ldA");
    applyStimulus(mk(1,0,1,0,0,1,0,   1, GT, 0,0,0,0,0), "sat ldB");
    for (int i = 1; i <= 260; i++) begin
      expQ.push_back(mk(1,1,0,0,1,0,0, 0, GT, 0,0, (i > 255) ? 255 : i, 0,0).e);
      driveVec(mk(1,1,0,0,1,0,0, 0, GT, 0,0,0,0,0));
      if (i == 1 || i >= 254) checkOutput($sformatf("sat%0d", i));
      else void'(expQ.pop_front());
    end
    // A must now be 300 - 260 = 40.
    applyStimulus(mk(1,0,0,0,0,0,1, 0, GT, 40,1,255,0,0), "sat capture");
`else
    // Watchdog with limit 3: A = 100, B = 1. A freezes at 97.
    driveVec(mk(0,0,0,0,0,0,0,   0, EQ, 0,0,0,0,0));
    cmp("lim reset timeout", 32'(limTimeout), 32'd0);
    driveVec(mk(1,1,0,0,0,1,0, 100, GT, 0,0,0,0,0));
    driveVec(mk(1,0,1,0,0,1,0,   1, GT, 0,0,0,0,0));
    for (int i = 1; i <= 5; i++) begin
      driveVec(mk(1,1,0,0,1,0,0, 0, GT, 0,0,0,0,0));
      cmp($sformatf("lim sub%0d timeout", i), 32'(limTimeout), (i >= 3) ? 32'd1 : 32'd0);
      cmp($sformatf("lim sub%0d iter", i), 32'(limIter), (i >= 3) ? 32'd3 : 32'(i));
    end
    driveVec(mk(1,0,0,0,0,0,1, 0, GT, 0,0,0,0,0));
    cmp("lim frozen A", 32'(limResult), 32'd97);
    driveVec(mk(1,1,0,0,0,1,0, 50, GT, 0,0,0,0,0));
    cmp("lim clear timeout", 32'(limTimeout), 32'd0);
    cmp("lim clear iter", 32'(limIter), 32'd0);
    expQ.delete();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gcd_datapath_unit.md
Name: gcd_datapath_unit

Overview:
- Datapath partner to the GCD controller. It responds to the controller's load and select strobes (ldA, ldB, sel1, sel2, sel_in) and returns the compare flags lt, gt and eq.
- Holds operand registers A and B, a shared subtractor, input and subtract muxes, and the magnitude comparator.
- Adds three registered side functions: result capture on done, an iteration counter, and sticky error flags. System logic can therefore read the GCD and detect misuse without probing the controller.

Parameters:
- WIDTH, 16, operand, result and data_in width.
- CNT_W, 8, iteration counter width.
- ITER_LIMIT, 200, watchdog threshold. Used only when GCD_ITER_LIMIT_EN is defined.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- data_in  in  WIDTH  operand bus from host.
- ldA  in  1  load A from bus.
- ldB  in  1  load B from bus.
- sel1  in  1  subtractor minuend select: 1 = B, 0 = A.
- sel2  in  1  subtractor subtrahend select: 1 = B, 0 = A.
- sel_in  in  1  bus select: 1 = data_in, 0 = subtractor output.
- done  in  1  controller done level.
- lt  out  1  A < B.
- gt  out  1  A > B.
- eq  out  1  A == B.
- result  out  WIDTH  captured GCD.
- result_valid  out  1  result holds a valid GCD.
- iter_count  out  CNT_W  subtract loads since last operand-A load.
- zero_err  out  1  sticky: subtract with zero subtrahend.
- proto_err  out  1  sticky: illegal strobe combination.

Behaviour:
- Reset (rst_n = 0 at posedge):
  - A, B, result and iter_count clear to 0.
  - result_valid, zero_err and proto_err clear to 0.
  - Reset mid-computation aborts immediately; no partial result is retained.
- Bus:
  - bus = sel_in ? data_in : sub.
  - sub = X - Y, where X = sel1 ? B : A and Y = sel2 ? B : A.
  - sub is a WIDTH-bit subtraction.
- Register writes:
  - At posedge, ldA writes A <= bus and ldB writes B <= bus.
  - Writes are suppressed in any cycle flagged illegal (see proto_err).
- Compare flags:
  - lt, gt and eq are combinational from registered A and B only, so they are valid the cycle after a load.
  - Exactly one of lt, gt, eq is 1 at all times, including after reset (A = B = 0, so eq = 1).
- Illegal cycle conditions (proto_err set):
  - ldA and ldB asserted together.
  - A load with sel_in = 0 and sel1 == sel2.
  - A load with sel_in = 0 whose subtraction would underflow (X < Y).
  - proto_err is sticky until reset.
- zero_err:
  - Set when a legal subtract load has Y == 0; the write still occurs.
  - Cleared by a legal load with sel_in = 1 and ldA = 1.
- iter_count:
  - Cleared to 0 on a legal operand-A load (sel_in = 1, ldA = 1).
  - +1 on each legal subtract load (sel_in = 0).
  - Saturates at all ones.
- Result capture:
  - On the first posedge where done = 1 and the previous done was 0: result <= A and result_valid <= 1.
  - result_valid stays 1 until the next legal operand-A load, which clears it in the same edge.
  - done held high does not recapture.
  - A simultaneous done rise and operand-A load: the load wins, result_valid = 0 and result is unchanged.

Optional Feature:
- GCD_ITER_LIMIT_EN defined:
  - Adds output port timeout (1 bit), reset 0.
  - timeout is set when a legal subtract load brings iter_count to ITER_LIMIT.
  - While timeout = 1, all subtract loads are suppressed.
  - timeout is cleared by a legal operand-A load.
- GCD_ITER_LIMIT_EN undefined:
  - No timeout port and no limit; ITER_LIMIT is ignored.

Test Plan:
- Load A = 48 (sel_in = 1, ldA), then B = 18 (ldB), then drive the controller sequence:
  - gt: A = 30 → gt: A = 12 → lt: B = 6 → gt: A = 6 → eq = 1.
  - Assert done → result = 6, result_valid = 1, iter_count = 4, no errors.
- A = 7, B = 7, then done → eq = 1 immediately, result = 7, iter_count = 0.
- A = 0, B = 5, then lt subtract (B = B - A) → zero_err = 1 and B stays 5. A new load of A = 9 clears zero_err and result_valid.
- ldA = ldB = 1 with data_in = 3 → proto_err = 1, A and B unchanged. Also a subtract load of A = A - B with A = 2, B = 5 → proto_err = 1, A stays 2.
- Mid-run (A = 30, B = 18) pull rst_n low for 1 cycle → all outputs 0, eq = 1. Done held high for 5 cycles after a valid result → a single capture.
- With GCD_ITER_LIMIT_EN and ITER_LIMIT = 3, run A = 100, B = 1 → timeout = 1 after the 3rd subtract, A = 97 frozen. A new operand load clears timeout.
